// File: rtl/div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : div_pkg                                                     |
// | Purpose  : Shared types and helpers for the iterative divider:         |
// |            FSM state enumeration and a two's-complement negation.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // neg() works on a fixed wide vector; callers zero-extend into it and
  // truncate the result back, which yields the correct low-order bits for
  // any operand width up to NEG_W.
  localparam int NEG_W = 64;

  function automatic logic [NEG_W-1:0] neg(input logic [NEG_W-1:0] v);
    return (~v) + NEG_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : div_step                                                    |
// | Purpose  : One radix-2 restoring division iteration (combinational).   |
// |            {rem,quo} is shifted left one bit, the divisor is trial-    |
// |            subtracted, and the quotient LSB records success.           |
// | Ports    : rem_in/quo_in  - current partial remainder / quotient       |
// |            divisor        - divisor magnitude                          |
// |            rem_out/quo_out- values after this iteration                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit holds the bit shifted out of rem so the trial
  // subtraction sees the true magnitude; diff[WIDTH] is the borrow.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_out = shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : div_iter                                                    |
// | Purpose  : WIDTH-generic iterative radix-2 restoring divider for the   |
// |            MIPS32 mul/div unit (DIV/DIVU). Quotient truncates toward   |
// |            zero, remainder takes the dividend's sign.                  |
// | Ports    : clk, rst_n (async, active-low)                              |
// |            start/sign/data_a/data_b - request, sampled when !busy      |
// |            busy  - operation in progress                               |
// |            done  - one-cycle pulse, results valid                      |
// |            data_q/data_r - quotient / remainder (held until next done) |
// |            dbz   - divide-by-zero flag, valid with done                |
// | Config   : DIV_ZERO_TRAP_EN - divisor 0 finishes two cycles after      |
// |            accept with dbz=1; otherwise full latency and dbz=0.        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_q,
  output logic [WIDTH-1:0] data_r,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             neg_q, neg_r;
  logic             b_zero, accept, trap;

  assign b_zero = (data_b == '0);
  assign busy   = (state == CALC) || (state == FIX);
  // OUT has busy=0, so a start coinciding with done is accepted.
  assign accept = start && !busy;

  assign mag_a = (sign && data_a[WIDTH-1]) ? WIDTH'(neg(NEG_W'(data_a))) : data_a;
  assign mag_b = (sign && data_b[WIDTH-1]) ? WIDTH'(neg(NEG_W'(data_b))) : data_b;
  assign fix_q = neg_q ? WIDTH'(neg(NEG_W'(quo))) : quo;
  assign fix_r = neg_r ? WIDTH'(neg(NEG_W'(rem))) : rem;

`ifdef DIV_ZERO_TRAP_EN
  assign trap = b_zero;
`else
  assign trap = 1'b0;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvs),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, OUT: begin
        state_nx = IDLE;
        if (accept) state_nx = trap ? FIX : CALC;
      end
      CALC:    if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:     state_nx = OUT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      data_q <= '0;
      data_r <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt   <= CNT_W'(WIDTH);
        dvs   <= mag_b;
        neg_r <= sign & data_a[WIDTH-1];
        if (trap) begin
          // Preload the raw restoring result for b=0 (q all ones,
          // rem = |a|) so FIX produces it without iterating.
          rem   <= mag_a;
          quo   <= '1;
          neg_q <= 1'b0;
        end else begin
          rem   <= '0;
          quo   <= mag_a;
          // A zero divisor keeps the raw all-ones quotient.
          neg_q <= sign & (data_a[WIDTH-1] ^ data_b[WIDTH-1]) & ~b_zero;
        end
      end else if (state == CALC) begin
        rem <= step_rem;
        quo <= step_quo;
        cnt <= cnt - CNT_W'(1);
      end else if (state == FIX) begin
        data_q <= fix_q;
        data_r <= fix_r;
        done   <= 1'b1;
      end
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  logic dbz_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_pend <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      if (accept)             dbz_pend <= trap;
      else if (state == FIX)  dbz      <= dbz_pend;
    end
  end
`else
  assign dbz = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_div_iter                                                 |
// | Purpose  : Self-checking bench for div_iter (WIDTH=32) against a plain |
// |            arithmetic reference of MIPS DIV/DIVU semantics.            |
// | Config   : DIV_ZERO_TRAP_EN selects the expected divide-by-zero path.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_div_iter;

  localparam int W = 32;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] data_q, data_r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sign   (sign),
    .data_a (data_a),
    .data_b (data_b),
    .busy   (busy),
    .done   (done),
    .data_q (data_q),
    .data_r (data_r),
    .dbz    (dbz)
  );

  // Reference: MIPS semantics via plain integer arithmetic.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    longint      sa, sb;
    logic [63:0] t;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t  = 64'(sa / sb);
      q  = t[W-1:0];
      t  = 64'(sa % sb);
      r  = t[W-1:0];
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
    return (TRAP && b == '0) ? 2 : W + 2;
  endfunction

  // Drives one request from the current time (away from an edge) and waits
  // for done. lat counts edges including the accepting edge.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit ok, output logic busy0);
    sign = s; data_a = a; data_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sign = 1'($urandom); data_a = $urandom; data_b = $urandom;
    busy0 = busy;
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    int lat; bit ok; logic b0;
    model(s, a, b, eq, er);
    run_op(s, a, b, lat, ok, b0);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: done never rose (a=%h b=%h)", name, a, b);
      return;
    end
    n_checks++;
    if (data_q !== eq) begin n_fail++; $display("FAIL %s q: got %h want %h (s=%0b a=%h b=%h)", name, data_q, eq, s, a, b); end
    n_checks++;
    if (data_r !== er) begin n_fail++; $display("FAIL %s r: got %h want %h (s=%0b a=%h b=%h)", name, data_r, er, s, a, b); end
    n_checks++;
    if (dbz !== (TRAP && b == '0)) begin n_fail++; $display("FAIL %s dbz: got %b want %b", name, dbz, (TRAP && b == '0)); end
    n_checks++;
    if (lat != exp_lat(b)) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat(b)); end
    n_checks++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL %s busy after accept: got %b want 1", name, b0); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, dbz} !== 3'b000) begin n_fail++; $display("FAIL reset flags: got busy/done/dbz=%b want 000", {busy, done, dbz}); end
    n_checks++;
    if (data_q !== '0) begin n_fail++; $display("FAIL reset q: got %h want 0", data_q); end
    n_checks++;
    if (data_r !== '0) begin n_fail++; $display("FAIL reset r: got %h want 0", data_r); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    check_op("signed_vec",   1'b1, 32'hFFFFFF01, 32'h00000030);
    check_op("unsigned_vec", 1'b0, 32'hFFFFFF01, 32'h00000030);
    check_op("min_by_m1",    1'b1, 32'h80000000, 32'hFFFFFFFF);
    check_op("dbz_unsigned", 1'b0, 32'h12345678, 32'h00000000);
    check_op("dbz_signed",   1'b1, 32'h87654321, 32'h00000000);
    // done must be exactly one cycle wide
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done width: got done=%b one cycle later want 0", done); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h80000000;
        2: b = (s && $urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h1;
        3: b = W'($urandom_range(1, 20));
        default: ;
      endcase
      if (s && $urandom_range(0, 3) == 0) b = -b;
      check_op("random", s, a, b);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] eq, er;
    bit seen;
    int extra;
    model(1'b1, 32'hFFFFFC18, 32'd7, eq, er);   // -1000 / 7
    sign = 1'b1; data_a = 32'hFFFFFC18; data_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    sign = 1'b0; data_a = 32'd999; data_b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ignore_start timeout: done=%b want 1", done); end
    n_checks++;
    if (data_q !== eq || data_r !== er) begin
      n_fail++; $display("FAIL ignore_start result: got q=%h r=%h want q=%h r=%h", data_q, data_r, eq, er);
    end
    extra = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL ignore_start second op: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_async_reset();
    sign = 1'b0; data_a = 32'hDEADBEEF; data_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, dbz} !== 3'b000) begin n_fail++; $display("FAIL async_reset flags: got busy/done/dbz=%b want 000", {busy, done, dbz}); end
    n_checks++;
    if (data_q !== '0 || data_r !== '0) begin n_fail++; $display("FAIL async_reset outputs: got q=%h r=%h want 0 0", data_q, data_r); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_op("after_reset", 1'b0, 32'd100, 32'd7);
    n_checks++;
    if (data_q !== 32'd14 || data_r !== 32'd2) begin n_fail++; $display("FAIL after_reset const: got q=%0d r=%0d want 14 2", data_q, data_r); end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first", 1'b1, 32'h00001234, 32'hFFFFFFF9);
    // Still in the done cycle: the next start must be accepted here.
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b done cycle: got done=%b want 1", done); end
    check_op("b2b_second", 1'b0, 32'hCAFEF00D, 32'h00000101);
    check_op("b2b_third",  1'b1, 32'h7FFFFFFF, 32'h80000000);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
